// File: rtl/stage_sequencer.sv
// Multi-cycle instruction sequencer: walks each instruction through fetch/decode/execute/
// optional data access/writeback, owns the PC, and watches memory handshakes for timeouts.
//
// state  | meaning
// IDLE   | one settling cycle after reset
// FETCH  | instruction request outstanding
// DECODE | decode enable pulse
// EXEC   | execute; next PC and op kind latched
// MEM    | data request outstanding
// WB     | register write and retire
// HALT   | stopped on request, reset only exit
// FAULT  | timeout or misaligned branch, reset only exit
module stage_sequencer #(
  parameter int              XLEN        = 32,
  parameter logic [XLEN-1:0] RESET_PC    = '0,
  parameter int              MEM_TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  input  logic            imem_ready,
  output logic            dmem_req,
  output logic            dmem_we,
  input  logic            dmem_ready,
  input  logic            is_load,
  input  logic            is_store,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  input  logic            halt_req,
  output logic            decode_en,
  output logic            exec_en,
  output logic            wb_en,
  output logic            rf_we,
  output logic [XLEN-1:0] pc,
  output logic [31:0]     retired_cnt,
  output logic [2:0]      state,
  output logic            fault
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;
  localparam logic [2:0] S_HALT   = 3'd6;
  localparam logic [2:0] S_FAULT  = 3'd7;

  localparam int              CW        = $clog2(MEM_TIMEOUT);
  localparam logic [CW-1:0]   WAIT_LAST = CW'(MEM_TIMEOUT - 1);

  logic [2:0]      r_state;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_next_pc;
  logic [31:0]     r_retired_cnt;
  logic            r_fault;
  logic            r_is_store;
  logic [CW-1:0]   r_wait_cnt;

  logic [2:0]      w_next_state;
  logic            w_wait_last;
  logic            w_waiting;
  logic            w_ready;

  assign w_wait_last = (r_wait_cnt == WAIT_LAST);
  assign w_waiting   = (r_state == S_FETCH) || (r_state == S_MEM);
  assign w_ready     = (r_state == S_FETCH) ? imem_ready : dmem_ready;

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:   w_next_state = S_FETCH;
      S_FETCH: begin
        if (imem_ready)       w_next_state = S_DECODE;
        else if (w_wait_last) w_next_state = S_FAULT;
      end
      S_DECODE: w_next_state = S_EXEC;
      S_EXEC: begin
        // Misaligned taken branch is fatal; a load+store combo is handled as a store in MEM.
        if (branch_taken && (branch_target[1:0] != 2'b00)) w_next_state = S_FAULT;
        else if (is_load || is_store)                       w_next_state = S_MEM;
        else                                                w_next_state = S_WB;
      end
      S_MEM: begin
        if (dmem_ready)       w_next_state = S_WB;
        else if (w_wait_last) w_next_state = S_FAULT;
      end
      S_WB:     w_next_state = halt_req ? S_HALT : S_FETCH;
      default:  w_next_state = r_state;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_pc          <= RESET_PC;
      r_next_pc     <= RESET_PC;
      r_retired_cnt <= '0;
      r_fault       <= 1'b0;
      r_is_store    <= 1'b0;
      r_wait_cnt    <= '0;
    end else begin
      r_state <= w_next_state;
      // Counter restarts whenever a new request window opens.
      if (w_next_state != r_state &&
          (w_next_state == S_FETCH || w_next_state == S_MEM))
        r_wait_cnt <= '0;
      else if (w_waiting && !w_ready)
        r_wait_cnt <= r_wait_cnt + 1'b1;
      if (r_state == S_EXEC) begin
        r_next_pc  <= branch_taken ? branch_target : r_pc + XLEN'(4);
        r_is_store <= is_store;
      end
      if (r_state == S_WB) begin
        r_pc          <= r_next_pc;
        r_retired_cnt <= r_retired_cnt + 32'd1;
      end
      if (r_state == S_FAULT)
        r_fault <= 1'b1;
    end
  end

  assign imem_req    = (r_state == S_FETCH);
  assign dmem_req    = (r_state == S_MEM);
  assign dmem_we     = (r_state == S_MEM) && r_is_store;
  assign decode_en   = (r_state == S_DECODE);
  assign exec_en     = (r_state == S_EXEC);
  assign wb_en       = (r_state == S_WB);
  assign rf_we       = (r_state == S_WB) && !r_is_store;
  assign pc          = r_pc;
  assign retired_cnt = r_retired_cnt;
  assign state       = r_state;
  assign fault       = r_fault;

endmodule

// File: tb/tb_stage_sequencer.sv
// Self-checking bench for stage_sequencer: per-instruction reference model predicts the
// state trace, handshake counts, PC and retire count from the instruction's parameters.
module tb_stage_sequencer;
  localparam int          XLEN        = 32;
  localparam logic [31:0] RESET_PC    = 32'h0;
  localparam int          MEM_TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req, imem_ready, dmem_req, dmem_we, dmem_ready;
  logic        is_load, is_store, branch_taken, halt_req;
  logic [31:0] branch_target;
  logic        decode_en, exec_en, wb_en, rf_we, fault;
  logic [31:0] pc, retired_cnt;
  logic [2:0]  state;

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] m_pc, m_ret;

  stage_sequencer #(.XLEN(XLEN), .RESET_PC(RESET_PC), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_ready(imem_ready),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ready(dmem_ready),
    .is_load(is_load), .is_store(is_store),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .halt_req(halt_req),
    .decode_en(decode_en), .exec_en(exec_en), .wb_en(wb_en), .rf_we(rf_we),
    .pc(pc), .retired_cnt(retired_cnt), .state(state), .fault(fault)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    imem_ready = 0; dmem_ready = 0; is_load = 0; is_store = 0;
    branch_taken = 0; branch_target = '0; halt_req = 0;
  endtask

  task automatic do_reset();
    rst = 1;
    drive_idle();
    step();
    step();
    rst = 0;
    m_pc  = RESET_PC;
    m_ret = 0;
  endtask

  task automatic go_fetch();
    do_reset();
    step();
  endtask

  // One instruction starting in FETCH; model predicts everything from (ld, st, tk, tgt, waits).
  task automatic run_instr(input bit ld, input bit st, input bit tk, input logic [31:0] tgt,
                           input int iw, input int dw, input bit hlt);
    logic [2:0]  exp_tr[$];
    logic [2:0]  obs_tr[$];
    bit          mem = ld | st;
    logic [31:0] exp_pc;
    int          fetch_n = 0, mem_n = 0, dreq = 0, bad_we = 0, bad_oh = 0;
    int          stray_rf = 0, wb_n = 0, n = 0;
    logic        wb_rf = 0;
    bit          seen_wb = 0;
    bit          ok;
    exp_pc = tk ? tgt : m_pc + 32'd4;
    for (int i = 0; i <= iw; i++) exp_tr.push_back(3'd1);
    exp_tr.push_back(3'd2);
    exp_tr.push_back(3'd3);
    if (mem) for (int i = 0; i <= dw; i++) exp_tr.push_back(3'd4);
    exp_tr.push_back(3'd5);

    vectors++;
    if (pc !== m_pc) begin
      miscompares++; $display("FAIL fetch_pc: got %h want %h", pc, m_pc);
    end

    while (n < 200 && !(seen_wb && state != 3'd5)) begin
      obs_tr.push_back(state);
      if (int'(decode_en) + int'(exec_en) + int'(wb_en) > 1) bad_oh++;
      if (dmem_req) begin
        dreq++;
        if (dmem_we !== st) bad_we++;
      end
      if (wb_en) begin
        wb_n++; wb_rf = rf_we; seen_wb = 1;
      end else if (rf_we) stray_rf++;
      if (imem_req) begin imem_ready = (fetch_n == iw); fetch_n++; end
      else imem_ready = 1'($urandom_range(0, 1));
      if (dmem_req) begin dmem_ready = (mem_n == dw); mem_n++; end
      else dmem_ready = 1'($urandom_range(0, 1));
      is_load = ld; is_store = st; branch_taken = tk; branch_target = tgt; halt_req = hlt;
      step();
      n++;
    end

    ok = (obs_tr.size() == exp_tr.size());
    if (ok) foreach (exp_tr[i]) if (obs_tr[i] !== exp_tr[i]) ok = 0;
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL state_trace: got %0d cycles want %0d cycles (ld=%0d st=%0d iw=%0d dw=%0d)",
               obs_tr.size(), exp_tr.size(), ld, st, iw, dw);
    end
    vectors++;
    if (state !== (hlt ? 3'd6 : 3'd1)) begin
      miscompares++; $display("FAIL end_state: got %0d want %0d", state, hlt ? 6 : 1);
    end
    vectors++;
    if (pc !== exp_pc) begin
      miscompares++; $display("FAIL next_pc: got %h want %h", pc, exp_pc);
    end
    vectors++;
    if (retired_cnt !== m_ret + 32'd1) begin
      miscompares++; $display("FAIL retired: got %h want %h", retired_cnt, m_ret + 32'd1);
    end
    vectors++;
    if (dreq != (mem ? dw + 1 : 0) || bad_we != 0) begin
      miscompares++;
      $display("FAIL dmem_cycles: got %0d (bad_we %0d) want %0d", dreq, bad_we, mem ? dw + 1 : 0);
    end
    vectors++;
    if (wb_n != 1 || wb_rf !== !st || stray_rf != 0) begin
      miscompares++;
      $display("FAIL rf_we: got wb=%0d rf_we=%0d stray=%0d want wb=1 rf_we=%0d stray=0",
               wb_n, wb_rf, stray_rf, !st);
    end
    vectors++;
    if (bad_oh != 0) begin
      miscompares++; $display("FAIL onehot: got %0d bad cycles want 0", bad_oh);
    end
    m_pc  = exp_pc;
    m_ret = m_ret + 32'd1;
  endtask

  task automatic test_reset();
    do_reset();
    vectors++;
    if (state !== 3'd0 || pc !== RESET_PC || retired_cnt !== 0 || fault !== 0) begin
      miscompares++;
      $display("FAIL reset_regs: got st=%0d pc=%h ret=%h f=%0d want 0/%h/0/0",
               state, pc, retired_cnt, fault, RESET_PC);
    end
    vectors++;
    if ({imem_req, dmem_req, dmem_we, decode_en, exec_en, wb_en, rf_we} !== 7'b0) begin
      miscompares++; $display("FAIL reset_outs: got nonzero request/enable want 0");
    end
    step();
    vectors++;
    if (state !== 3'd1 || imem_req !== 1'b1) begin
      miscompares++; $display("FAIL first_fetch: got st=%0d req=%0d want 1/1", state, imem_req);
    end
  endtask

  task automatic test_alu();
    go_fetch();
    run_instr(0, 0, 0, 32'h0, 0, 0, 0);
  endtask

  task automatic test_load_store();
    run_instr(1, 0, 0, 32'h0, 0, 3, 0);
    run_instr(0, 1, 0, 32'h0, 0, 3, 0);
    run_instr(1, 1, 0, 32'h0, 1, 0, 0);
  endtask

  task automatic test_branch();
    run_instr(0, 0, 1, 32'h100, 0, 0, 0);
    go_fetch();
    imem_ready = 1; step();
    imem_ready = 0; step();
    branch_taken = 1; branch_target = 32'h102;
    step();
    vectors++;
    if (state !== 3'd7 || pc !== m_pc || retired_cnt !== m_ret) begin
      miscompares++;
      $display("FAIL branch_misalign: got st=%0d pc=%h ret=%h want 7/%h/%h",
               state, pc, retired_cnt, m_pc, m_ret);
    end
    drive_idle();
    imem_ready = 1; dmem_ready = 1;
    step(); step(); step();
    vectors++;
    if (state !== 3'd7 || fault !== 1'b1 || pc !== m_pc ||
        {imem_req, dmem_req, decode_en, exec_en, wb_en, rf_we} !== 6'b0) begin
      miscompares++;
      $display("FAIL fault_sticky: got st=%0d fault=%0d pc=%h want 7/1/%h", state, fault, pc, m_pc);
    end
  endtask

  task automatic test_timeout();
    int n;
    go_fetch();
    imem_ready = 0;
    n = 0;
    while (state == 3'd1 && n < 100) begin step(); n++; end
    vectors++;
    if (n != MEM_TIMEOUT || state !== 3'd7 || fault !== 1'b0) begin
      miscompares++;
      $display("FAIL fetch_timeout: got %0d cycles st=%0d fault=%0d want %0d/7/0",
               n, state, fault, MEM_TIMEOUT);
    end
    step();
    vectors++;
    if (fault !== 1'b1 || pc !== m_pc) begin
      miscompares++; $display("FAIL timeout_fault: got fault=%0d pc=%h want 1/%h", fault, pc, m_pc);
    end
    go_fetch();
    run_instr(0, 0, 0, 32'h0, MEM_TIMEOUT - 1, 0, 0);
    run_instr(1, 0, 0, 32'h0, 0, MEM_TIMEOUT - 1, 0);
    vectors++;
    if (fault !== 1'b0) begin
      miscompares++; $display("FAIL ready_last_cycle: got fault=%0d want 0", fault);
    end
    go_fetch();
    is_load = 1; imem_ready = 1; step();
    imem_ready = 0; step(); step();
    n = 0;
    while (state == 3'd4 && n < 100) begin step(); n++; end
    vectors++;
    if (n != MEM_TIMEOUT || state !== 3'd7) begin
      miscompares++;
      $display("FAIL dmem_timeout: got %0d cycles st=%0d want %0d/7", n, state, MEM_TIMEOUT);
    end
  endtask

  task automatic test_halt();
    go_fetch();
    run_instr(0, 0, 0, 32'h0, 2, 0, 1);
    for (int i = 0; i < 5; i++) begin
      imem_ready = 1; dmem_ready = 1; halt_req = 1'($urandom_range(0, 1));
      step();
    end
    vectors++;
    if (state !== 3'd6 || pc !== m_pc || retired_cnt !== m_ret || imem_req !== 1'b0 || fault !== 0) begin
      miscompares++;
      $display("FAIL halt_frozen: got st=%0d pc=%h ret=%h want 6/%h/%h", state, pc, retired_cnt, m_pc, m_ret);
    end
  endtask

  task automatic test_reset_mid_mem();
    go_fetch();
    run_instr(0, 0, 0, 32'h0, 0, 0, 0);
    imem_ready = 1; is_store = 1; step();
    imem_ready = 0; step(); step();
    dmem_ready = 0; step();
    rst = 1; step();
    vectors++;
    if (state !== 3'd0 || pc !== RESET_PC || retired_cnt !== 0 || dmem_req !== 0 || fault !== 0) begin
      miscompares++;
      $display("FAIL reset_mid_mem: got st=%0d pc=%h ret=%h dreq=%0d want 0/%h/0/0",
               state, pc, retired_cnt, dmem_req, RESET_PC);
    end
    rst = 0; m_pc = RESET_PC; m_ret = 0;
    drive_idle();
    step();
    run_instr(0, 0, 0, 32'h0, MEM_TIMEOUT - 1, 0, 0);
  endtask

  task automatic test_wrap();
    go_fetch();
    force dut.r_retired_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.r_retired_cnt;
    m_ret = 32'hFFFF_FFFF;
    run_instr(0, 0, 0, 32'h0, 0, 0, 0);
  endtask

  task automatic test_random();
    go_fetch();
    for (int k = 0; k < 30; k++) begin
      int          kind;
      logic [31:0] tgt;
      kind = $urandom_range(0, 4);
      tgt  = $urandom & 32'hFFFF_FFFC;
      run_instr(kind == 1 || kind == 3, kind == 2 || kind == 3,
                kind == 4 || ($urandom_range(0, 3) == 0), tgt,
                $urandom_range(0, 4), $urandom_range(0, 4), 0);
    end
  endtask

  initial begin
    rst = 1;
    drive_idle();
    test_reset();
    test_alu();
    test_load_store();
    test_branch();
    test_timeout();
    test_halt();
    test_reset_mid_mem();
    test_wrap();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
